seq_mult_ctrl_taint_v2: RTL and testbench

SEQ_MULT_CTRL_TAINT_V2 -- requirements
Module: seq_mult_ctrl_taint_v2

---
 rtl/seq_mult_ctrl_taint_v2_if.sv | 29 ++
 rtl/seq_mult_ctrl_taint_v2.sv | 115 +++++++++++
 tb/tb_seq_mult_ctrl_taint_v2.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_ctrl_taint_v2_if.sv
// Handshake and datapath-control bundle between the sequential multiplier
// controller and its datapath/requester, with per-signal taint companions.
interface seq_mult_ctrl_taint_v2_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             start_t;
  logic [WIDTH-1:0] multiplierReg;
  logic [WIDTH-1:0] multiplierReg_t;

  logic mdld,    mrld,    rsclear,    rsload,    rsshr;
  logic mdld_t,  mrld_t,  rsclear_t,  rsload_t,  rsshr_t;
  logic productDone, productDone_t;
  logic busy,        busy_t;

  modport master (
    output start, start_t, multiplierReg, multiplierReg_t,
    input  mdld, mrld, rsclear, rsload, rsshr,
    input  mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t,
    input  productDone, productDone_t, busy, busy_t
  );

  modport slave (
    input  start, start_t, multiplierReg, multiplierReg_t,
    output mdld, mrld, rsclear, rsload, rsshr,
    output mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t,
    output productDone, productDone_t, busy, busy_t
  );
endinterface

// File: rtl/seq_mult_ctrl_taint_v2.sv
// Shift-and-add multiplier controller (Moore FSM) with a single state-level
// taint bit that follows every control-flow decision the FSM makes.
module seq_mult_ctrl_taint_v2 #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  seq_mult_ctrl_taint_v2_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            state_t_q, state_t_d;
  logic            cnt_t_q, cnt_t_d;

  logic [CW-1:0]   cnt_inc;
  logic            cnt_last;
  logic            bit_next;
  logic            bit_next_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      state_t_q <= 1'b0;
      cnt_t_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      state_t_q <= state_t_d;
      cnt_t_q   <= cnt_t_d;
    end
  end

  // Only the bit about to be processed may influence control flow or taint.
  always_comb begin
    cnt_inc    = cnt_q + 1'b1;
    cnt_last   = (cnt_q == CW'(WIDTH - 1));
    bit_next   = cnt_last ? 1'b0 : bus.multiplierReg[cnt_inc];
    bit_next_t = cnt_last ? 1'b0 : bus.multiplierReg_t[cnt_inc];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    state_t_d = state_t_q;
    cnt_t_d   = cnt_t_q;

    unique case (state_q)
      IDLE: begin
        state_t_d = bus.start_t;
        if (bus.start) begin
          state_d = INIT;
        end
      end
      INIT: begin
        cnt_d     = '0;
        cnt_t_d   = state_t_q;
        state_t_d = state_t_q | bus.multiplierReg_t[0];
        state_d   = bus.multiplierReg[0] ? LOAD : SHIFT;
      end
      LOAD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_t_d = cnt_t_q | state_t_q;
        if (cnt_last) begin
          cnt_d     = '0;
          state_t_d = state_t_q | cnt_t_q;
          state_d   = DONE;
        end else begin
          cnt_d     = cnt_inc;
          state_t_d = state_t_q | cnt_t_q | bit_next_t;
          state_d   = bit_next ? LOAD : SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the registered state only; taints mirror the state taint.
  always_comb begin
    bus.mdld        = (state_q == INIT);
    bus.mrld        = (state_q == INIT);
    bus.rsclear     = (state_q == INIT);
    bus.rsload      = (state_q == LOAD);
    bus.rsshr       = (state_q == SHIFT);
    bus.productDone = (state_q == DONE);
    bus.busy        = (state_q != IDLE);

    bus.mdld_t        = state_t_q;
    bus.mrld_t        = state_t_q;
    bus.rsclear_t     = state_t_q;
    bus.rsload_t      = state_t_q;
    bus.rsshr_t       = state_t_q;
    bus.productDone_t = state_t_q;
    bus.busy_t        = state_t_q;
  end

endmodule

// File: tb/tb_seq_mult_ctrl_taint_v2.sv
// Scoreboard bench: stimulus queues hand-written per-cycle traces and
// completion expectations; negedge monitors pop and compare.
module tb_seq_mult_ctrl_taint_v2;

  logic clk;
  logic rst;
  int   cyc = 0;

  seq_mult_ctrl_taint_v2_if #(.WIDTH(4)) bus4 ();
  seq_mult_ctrl_taint_v2_if #(.WIDTH(8)) bus8 ();

  seq_mult_ctrl_taint_v2 #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_mult_ctrl_taint_v2 #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [13:0] word;
  } exp_t;

  typedef struct {
    int   s;
    int   lat;
    logic t;
  } done_t;

  exp_t  q4[$];
  exp_t  q8[$];
  done_t d4[$];
  done_t d8[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // {mdld,mrld,rsclear,rsload,rsshr,productDone,busy}
  function automatic logic [6:0] dec(input byte c);
    case (c)
      "N":     return 7'b1110001;
      "L":     return 7'b0001001;
      "S":     return 7'b0000101;
      "D":     return 7'b0000011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic push_trace(input bit w8, input int s, input string st, input string tt);
    exp_t e;
    for (int i = 0; i < st.len(); i++) begin
      e.cyc  = s + i;
      e.word = {dec(st[i]), (tt[i] == 8'h31) ? 7'h7F : 7'h00};
      if (w8) q8.push_back(e);
      else    q4.push_back(e);
    end
  endtask

  task automatic push_done(input bit w8, input int s, input int lat, input logic t);
    done_t d;
    d.s = s; d.lat = lat; d.t = t;
    if (w8) d8.push_back(d);
    else    d4.push_back(d);
  endtask

  function automatic logic [13:0] pack4();
    return {bus4.mdld, bus4.mrld, bus4.rsclear, bus4.rsload, bus4.rsshr, bus4.productDone, bus4.busy,
            bus4.mdld_t, bus4.mrld_t, bus4.rsclear_t, bus4.rsload_t, bus4.rsshr_t, bus4.productDone_t,
            bus4.busy_t};
  endfunction

  function automatic logic [13:0] pack8();
    return {bus8.mdld, bus8.mrld, bus8.rsclear, bus8.rsload, bus8.rsshr, bus8.productDone, bus8.busy,
            bus8.mdld_t, bus8.mrld_t, bus8.rsclear_t, bus8.rsload_t, bus8.rsshr_t, bus8.productDone_t,
            bus8.busy_t};
  endfunction

  exp_t  e4, e8;
  done_t x4, x8;

  always @(negedge clk) begin
    while (q4.size() > 0 && q4[0].cyc <= cyc) begin
      e4 = q4.pop_front();
      chk($sformatf("w4_trace_cyc%0d", e4.cyc), {18'd0, pack4()}, {18'd0, e4.word});
    end
    if (bus4.productDone === 1'b1) begin
      if (d4.size() == 0) begin
        checks++;
        $display("FAIL w4_unexpected_done: got productDone=1 at cyc %0d expected none", cyc);
      end else begin
        x4 = d4.pop_front();
        chk("w4_done_latency", cyc - x4.s + 1, x4.lat);
        chk("w4_done_taint", {31'd0, bus4.productDone_t}, {31'd0, x4.t});
      end
    end
  end

  always @(negedge clk) begin
    while (q8.size() > 0 && q8[0].cyc <= cyc) begin
      e8 = q8.pop_front();
      chk($sformatf("w8_trace_cyc%0d", e8.cyc), {18'd0, pack8()}, {18'd0, e8.word});
    end
    if (bus8.productDone === 1'b1) begin
      if (d8.size() == 0) begin
        checks++;
        $display("FAIL w8_unexpected_done: got productDone=1 at cyc %0d expected none", cyc);
      end else begin
        x8 = d8.pop_front();
        chk("w8_done_latency", cyc - x8.s + 1, x8.lat);
        chk("w8_done_taint", {31'd0, bus8.productDone_t}, {31'd0, x8.t});
      end
    end
  end

  int s;

  initial begin
    rst = 1'b1;
    bus4.start = 1'b0; bus4.start_t = 1'b0; bus4.multiplierReg = '0; bus4.multiplierReg_t = '0;
    bus8.start = 1'b0; bus8.start_t = 1'b0; bus8.multiplierReg = '0; bus8.multiplierReg_t = '0;

    repeat (3) @(negedge clk);
    push_trace(1'b0, cyc + 1, "I", "0");
    push_trace(1'b1, cyc + 1, "I", "0");
    @(negedge clk);
    rst = 1'b0;

    // 4'b1011, untainted
    @(negedge clk);
    bus4.multiplierReg = 4'b1011; bus4.start = 1'b1; s = cyc + 1;
    push_trace(1'b0, s, "NLSLSSLSDI", "0000000000");
    push_done(1'b0, s, 9, 1'b0);
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (11) @(negedge clk);

    // zero multiplier: no loads
    bus4.multiplierReg = 4'b0000; bus4.start = 1'b1; s = cyc + 1;
    push_trace(1'b0, s, "NSSSSDI", "0000000");
    push_done(1'b0, s, 6, 1'b0);
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (8) @(negedge clk);

    // taint on bit 2 only shows once bit 2 is indexed
    bus4.multiplierReg = 4'b0001; bus4.multiplierReg_t = 4'b0100; bus4.start = 1'b1; s = cyc + 1;
    push_trace(1'b0, s, "NLSSSSDII", "000011110");
    push_done(1'b0, s, 7, 1'b1);
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (10) @(negedge clk);
    bus4.multiplierReg_t = 4'b0000;

    // taint on start alone while idle
    bus4.start_t = 1'b1; s = cyc + 1;
    push_trace(1'b0, s, "II", "10");
    @(negedge clk);
    bus4.start_t = 1'b0;
    repeat (3) @(negedge clk);

    // reset during second SHIFT with start held high
    bus4.multiplierReg = 4'b1011; bus4.start = 1'b1; s = cyc + 1;
    push_trace(1'b0, s, "NLSLSINI", "00000000");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus4.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // WIDTH=8, all ones, start held high: one done, then immediate restart
    bus8.multiplierReg = 8'hFF; bus8.start = 1'b1; s = cyc + 1;
    push_trace(1'b1, s, "NLSLSLSLSLSLSLSLSDIN", "00000000000000000000");
    push_trace(1'b1, s + 20, "I", "0");
    push_done(1'b1, s, 18, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1; bus8.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("w4_trace_pending", q4.size(), 0);
    chk("w8_trace_pending", q8.size(), 0);
    chk("w4_done_pending", d4.size(), 0);
    chk("w8_done_pending", d8.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
